// File: rtl/stack_sequencer_if.sv
// Bus bundle between the control unit, the stack sequencer and data memory.
// Optional peek request is present only when STACK_PEEK_EN is defined.
interface stack_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Control-unit request side
    logic              psh;
    logic              pop;
`ifdef STACK_PEEK_EN
    logic              peek;
`endif
    logic [DATA_W-1:0] push_data;
    logic              clr_err;

    // Result / status side
    logic [DATA_W-1:0] pop_data;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] sp;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              unf;
    logic [1:0]        state_dbg;

    // Single-port synchronous data memory
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Handshake: psh/pop (and peek) are single-cycle requests sampled only
    // while busy is low; each accepted request finishes with exactly one
    // done pulse, refused requests raise ovf/unf instead and never pulse done.
    modport slave (
        input  psh, pop, push_data, clr_err, mem_rdata,
`ifdef STACK_PEEK_EN
        input  peek,
`endif
        output pop_data, done, busy, sp, count, empty, full, ovf, unf,
        output state_dbg, mem_addr, mem_wr, mem_rd, mem_wdata
    );

    modport master (
        output psh, pop, push_data, clr_err, mem_rdata,
`ifdef STACK_PEEK_EN
        output peek,
`endif
        input  pop_data, done, busy, sp, count, empty, full, ovf, unf,
        input  state_dbg, mem_addr, mem_wr, mem_rd, mem_wdata
    );
endinterface

// File: rtl/stack_sequencer.sv
// Hardware stack sequencer: owns the stack pointer and occupancy count and
// turns psh/pop strobes into single-port data-memory accesses. The stack
// grows downward from STACK_BASE; sp always points at the next free slot.
// Optional macro STACK_PEEK_EN adds a non-destructive top-of-stack read.
module stack_sequencer #(
    parameter int              DATA_W     = 16,
    parameter int              ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] STACK_BASE = 10'h3FF,
    parameter int              DEPTH      = 64
) (
    input logic               clk,
    input logic               rst,
    stack_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] sp_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] pop_data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic              rd_q;
    logic              done_q;
    logic              ovf_q;
    logic              unf_q;
    logic              is_empty;
    logic              is_full;
`ifdef STACK_PEEK_EN
    logic              peek_q;   // current READ/CAPTURE leaves sp/count alone
`endif

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // Sequencer FSM: all memory strobes and status are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sp_q       <= STACK_BASE;
            count_q    <= '0;
            wdata_q    <= '0;
            pop_data_q <= '0;
            addr_q     <= STACK_BASE;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef STACK_PEEK_EN
            peek_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            // Clear first so an error detected in the same cycle wins.
            if (bus.clr_err) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.psh) begin
                        // Push wins over a simultaneous pop; the pop is dropped.
                        if (is_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wdata_q <= bus.push_data;
                            wr_q    <= 1'b1;
                            addr_q  <= sp_q;
                            state   <= WRITE;
                        end
                    end else if (bus.pop) begin
                        if (is_empty) begin
                            unf_q <= 1'b1;
                        end else begin
                            rd_q   <= 1'b1;
                            addr_q <= sp_q + ADDR_W'(1);
                            state  <= READ;
`ifdef STACK_PEEK_EN
                            peek_q <= 1'b0;
`endif
                        end
`ifdef STACK_PEEK_EN
                    end else if (bus.peek) begin
                        if (is_empty) begin
                            unf_q <= 1'b1;
                        end else begin
                            rd_q   <= 1'b1;
                            addr_q <= sp_q + ADDR_W'(1);
                            state  <= READ;
                            peek_q <= 1'b1;
                        end
`endif
                    end
                end
                WRITE: begin
                    sp_q    <= sp_q - ADDR_W'(1);
                    count_q <= count_q + CNT_W'(1);
                    addr_q  <= sp_q - ADDR_W'(1);
                    done_q  <= 1'b1;
                    state   <= IDLE;
                end
                READ: begin
                    // Memory returns the word during CAPTURE; address idles at new sp.
`ifdef STACK_PEEK_EN
                    if (peek_q) begin
                        addr_q <= sp_q;
                    end else begin
                        sp_q    <= sp_q + ADDR_W'(1);
                        count_q <= count_q - CNT_W'(1);
                        addr_q  <= sp_q + ADDR_W'(1);
                    end
`else
                    sp_q    <= sp_q + ADDR_W'(1);
                    count_q <= count_q - CNT_W'(1);
                    addr_q  <= sp_q + ADDR_W'(1);
`endif
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    pop_data_q <= bus.mem_rdata;
                    done_q     <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output wiring onto the bus bundle.
    always_comb begin
        bus.pop_data  = pop_data_q;
        bus.done      = done_q;
        bus.busy      = (state != IDLE);
        bus.sp        = sp_q;
        bus.count     = count_q;
        bus.empty     = is_empty;
        bus.full      = is_full;
        bus.ovf       = ovf_q;
        bus.unf       = unf_q;
        bus.state_dbg = state;
        bus.mem_addr  = addr_q;
        bus.mem_wr    = wr_q;
        bus.mem_rd    = rd_q;
        bus.mem_wdata = wdata_q;
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: a queue-based stack model and a
// behavioural synchronous memory; directed scenarios plus random push/pop.
module tb_stack_sequencer;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 64;
    localparam logic [AW-1:0] BASE = 10'h3FF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stack_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();

    stack_sequencer #(.DATA_W(DW), .ADDR_W(AW), .STACK_BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / memory model
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Scoreboard: stack contents in push order, sticky flags, last pop
    logic [DW-1:0] exp_q[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_pop;
    int            n_checks;
    int            n_errors;

    function automatic logic [AW-1:0] exp_sp();
        return BASE - AW'(exp_q.size());
    endfunction

    // Driver: push (optionally with a simultaneous pop), check timing and status
    task automatic do_push(input logic [DW-1:0] d, input logic with_pop);
        logic          was_full;
        logic [AW-1:0] e_addr;
        was_full = (exp_q.size() == DEPTH);
        e_addr   = exp_sp();
        bus.psh = 1'b1; bus.pop = with_pop; bus.push_data = d;
        @(negedge clk);
        bus.psh = 1'b0; bus.pop = 1'b0;
        if (was_full) begin
            m_ovf = 1'b1;
            n_checks++; if (bus.mem_wr !== 1'b0 || bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_errors++; $display("FAIL push_full_quiet: wr=%b rd=%b busy=%b done=%b expected all 0", bus.mem_wr, bus.mem_rd, bus.busy, bus.done); end
            n_checks++; if (bus.ovf !== 1'b1 || bus.count !== 7'(DEPTH)) begin
                n_errors++; $display("FAIL push_full_ovf: ovf=%b count=%0d expected 1/%0d", bus.ovf, bus.count, DEPTH); end
            return;
        end
        n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== e_addr || bus.mem_wdata !== d) begin
            n_errors++; $display("FAIL push_write: wr=%b rd=%b addr=%h wdata=%h expected 1/0/%h/%h", bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata, e_addr, d); end
        @(negedge clk);
        exp_q.push_back(d);
        n_checks++; if (bus.done !== 1'b1 || bus.sp !== exp_sp() || bus.count !== 7'(exp_q.size())) begin
            n_errors++; $display("FAIL push_done: done=%b sp=%h count=%0d expected 1/%h/%0d", bus.done, bus.sp, bus.count, exp_sp(), exp_q.size()); end
        n_checks++; if (bus.empty !== 1'b0 || bus.full !== (exp_q.size() == DEPTH) || bus.ovf !== m_ovf || bus.unf !== m_unf) begin
            n_errors++; $display("FAIL push_flags: empty=%b full=%b ovf=%b unf=%b expected 0/%b/%b/%b", bus.empty, bus.full, bus.ovf, bus.unf, exp_q.size() == DEPTH, m_ovf, m_unf); end
    endtask

    // Driver: pop, check read timing, LIFO data and status
    task automatic do_pop();
        logic          was_empty;
        logic [AW-1:0] e_addr;
        was_empty = (exp_q.size() == 0);
        e_addr    = exp_sp() + AW'(1);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        if (was_empty) begin
            m_unf = 1'b1;
            n_checks++; if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_errors++; $display("FAIL pop_empty_quiet: rd=%b busy=%b done=%b expected 0/0/0", bus.mem_rd, bus.busy, bus.done); end
            n_checks++; if (bus.unf !== 1'b1 || bus.pop_data !== m_pop) begin
                n_errors++; $display("FAIL pop_empty_unf: unf=%b pop_data=%h expected 1/%h", bus.unf, bus.pop_data, m_pop); end
            return;
        end
        n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== e_addr) begin
            n_errors++; $display("FAIL pop_read: rd=%b wr=%b addr=%h expected 1/0/%h", bus.mem_rd, bus.mem_wr, bus.mem_addr, e_addr); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.mem_rd !== 1'b0) begin
            n_errors++; $display("FAIL pop_capture: done=%b busy=%b rd=%b expected 0/1/0", bus.done, bus.busy, bus.mem_rd); end
        @(negedge clk);
        m_pop = exp_q.pop_back();
        n_checks++; if (bus.done !== 1'b1 || bus.pop_data !== m_pop) begin
            n_errors++; $display("FAIL pop_done: done=%b pop_data=%h expected 1/%h", bus.done, bus.pop_data, m_pop); end
        n_checks++; if (bus.sp !== exp_sp() || bus.count !== 7'(exp_q.size()) || bus.empty !== (exp_q.size() == 0) || bus.full !== 1'b0) begin
            n_errors++; $display("FAIL pop_status: sp=%h count=%0d empty=%b full=%b expected %h/%0d/%b/0", bus.sp, bus.count, bus.empty, bus.full, exp_sp(), exp_q.size(), exp_q.size() == 0); end
    endtask

    task automatic do_clr();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        n_checks++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
            n_errors++; $display("FAIL clr_err: ovf=%b unf=%b expected 0/0", bus.ovf, bus.unf); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.sp !== BASE || bus.count !== 7'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            n_errors++; $display("FAIL reset_status: sp=%h count=%0d empty=%b full=%b expected 3ff/0/1/0", bus.sp, bus.count, bus.empty, bus.full); end
        n_checks++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_rd !== 1'b0 || bus.pop_data !== 16'h0) begin
            n_errors++; $display("FAIL reset_outputs: ovf=%b unf=%b done=%b busy=%b wr=%b rd=%b pop_data=%h expected all 0", bus.ovf, bus.unf, bus.done, bus.busy, bus.mem_wr, bus.mem_rd, bus.pop_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_push_basic();
        do_push(16'hA5A5, 1'b0);
        n_checks++; if (bus.sp !== 10'h3FE || bus.count !== 7'd1) begin
            n_errors++; $display("FAIL push_basic_const: sp=%h count=%0d expected 3fe/1", bus.sp, bus.count); end
        do_pop();
    endtask

    task automatic test_push_pop();
        do_push(16'h1111, 1'b0);
        do_push(16'h2222, 1'b0);
        do_pop();
        n_checks++; if (bus.pop_data !== 16'h2222) begin
            n_errors++; $display("FAIL lifo_first: pop_data=%h expected 2222", bus.pop_data); end
        do_pop();
        n_checks++; if (bus.pop_data !== 16'h1111 || bus.sp !== 10'h3FF || bus.empty !== 1'b1) begin
            n_errors++; $display("FAIL lifo_second: pop_data=%h sp=%h empty=%b expected 1111/3ff/1", bus.pop_data, bus.sp, bus.empty); end
    endtask

    task automatic test_underflow();
        do_pop();
        @(negedge clk);
        n_checks++; if (bus.unf !== 1'b1 || bus.pop_data !== 16'h1111 || bus.done !== 1'b0) begin
            n_errors++; $display("FAIL unf_sticky: unf=%b pop_data=%h done=%b expected 1/1111/0", bus.unf, bus.pop_data, bus.done); end
        do_clr();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) do_push(16'($urandom), 1'b0);
        n_checks++; if (bus.full !== 1'b1 || bus.sp !== 10'h3BF) begin
            n_errors++; $display("FAIL fill_full: full=%b sp=%h expected 1/3bf", bus.full, bus.sp); end
        do_push(16'hDEAD, 1'b0);
        do_push(16'hBEEF, 1'b1);
        do_clr();
        for (int i = 0; i < DEPTH; i++) do_pop();
    endtask

    task automatic test_simultaneous();
        do_push(16'h7E57, 1'b1);
        n_checks++; if (bus.count !== 7'd1 || bus.unf !== 1'b0) begin
            n_errors++; $display("FAIL simul_push_wins: count=%0d unf=%b expected 1/0", bus.count, bus.unf); end
        do_pop();
    endtask

    task automatic test_busy_ignore();
        bus.psh = 1'b1; bus.push_data = 16'hC0DE;
        @(negedge clk);
        bus.push_data = 16'hBAD0;   // still requesting while WRITE is in progress
        n_checks++; if (bus.mem_wdata !== 16'hC0DE || bus.busy !== 1'b1) begin
            n_errors++; $display("FAIL busy_write: wdata=%h busy=%b expected c0de/1", bus.mem_wdata, bus.busy); end
        @(negedge clk);
        bus.psh = 1'b0;
        exp_q.push_back(16'hC0DE);
        @(negedge clk);
        n_checks++; if (bus.count !== 7'(exp_q.size()) || bus.busy !== 1'b0 || bus.mem_wr !== 1'b0) begin
            n_errors++; $display("FAIL busy_ignored: count=%0d busy=%b wr=%b expected %0d/0/0", bus.count, bus.busy, bus.mem_wr, exp_q.size()); end
        do_pop();
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      do_push(16'($urandom), 1'($urandom_range(0, 1)));
            else if (r < 9) do_pop();
            else            do_clr();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        while (exp_q.size() > 0) do_pop();
    endtask

    task automatic test_reset_mid_read();
        do_push(16'hBEEF, 1'b0);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        n_checks++; if (bus.mem_rd !== 1'b1) begin
            n_errors++; $display("FAIL rst_read_issued: rd=%b expected 1", bus.mem_rd); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.mem_rd !== 1'b0 || bus.sp !== BASE || bus.count !== 7'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++; $display("FAIL rst_abort: rd=%b sp=%h count=%0d busy=%b done=%b expected 0/3ff/0/0/0", bus.mem_rd, bus.sp, bus.count, bus.busy, bus.done); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_pop = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (bus.done !== 1'b0 || bus.pop_data !== 16'h0) begin
                n_errors++; $display("FAIL rst_no_done: done=%b pop_data=%h expected 0/0000", bus.done, bus.pop_data); end
        end
        do_push(16'h5A5A, 1'b0);
        do_pop();
    endtask

    initial begin
        bus.psh = 1'b0; bus.pop = 1'b0; bus.push_data = '0; bus.clr_err = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_pop = '0;
        n_checks = 0; n_errors = 0;
        test_reset();
        test_push_basic();
        test_push_pop();
        test_underflow();
        test_fill_overflow();
        test_simultaneous();
        test_busy_ignore();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
